// File: rtl/ascon_width_fifo.sv
// Block FIFO with bus/block width conversion for the Ascon AD/PT/CT paths.
// Mode 0 packs bus words MSB-first into blocks; Mode 1 unpacks blocks into bus words.
module ascon_width_fifo #(
  parameter int unsigned BusWidth   = 32,
  parameter int unsigned BlockWidth = 64,
  parameter int unsigned Depth      = 4,
  parameter int unsigned Mode       = 0,
  localparam int unsigned InWidth   = (Mode != 0) ? BlockWidth : BusWidth,
  localparam int unsigned OutWidth  = (Mode != 0) ? BusWidth : BlockWidth,
  localparam int unsigned LvlW      = $clog2(Depth + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [InWidth-1:0]  data_i,
  input  logic                commit_i,
  output logic                full_o,
  input  logic                pop_i,
  output logic [OutWidth-1:0] data_o,
  output logic                empty_o,
  output logic [LvlW-1:0]     level_o,
  output logic                partial_o
);

  localparam int unsigned R    = BlockWidth / BusWidth;
  localparam int unsigned CntW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned IdxW = $clog2(BlockWidth);
  localparam logic [CntW-1:0] LastCnt = CntW'(R - 1);

  logic [BlockWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [LvlW-1:0]       r_level;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_blk_wr;
  logic                  w_release;
  logic [BlockWidth-1:0] w_blk;
  logic [BlockWidth-1:0] w_head;

  assign w_full    = (r_level == LvlW'(Depth));
  assign w_empty   = (r_level == '0);
  assign w_push_ok = push_i && !w_full;
  assign w_pop_ok  = pop_i && !w_empty;
  assign w_head    = r_mem[r_rptr];

  assign full_o    = w_full;
  assign empty_o   = w_empty;
  assign level_o   = r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_blk_wr) begin
        r_mem[r_wptr] <= w_blk;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_release) r_rptr <= r_rptr + 1'b1;
      case ({w_blk_wr, w_release})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  if (Mode == 0) begin : g_upsize
    logic [CntW-1:0]       r_wc;
    logic [BlockWidth-1:0] r_asm;
    logic [BlockWidth-1:0] w_asm_next;
    logic                  w_last;

    assign w_last = (r_wc == LastCnt);

    always_comb begin
      w_asm_next = r_asm;
      if (w_push_ok) begin
        for (int unsigned k = 0; k < R; k++) begin
          if (r_wc == CntW'(k))
            w_asm_next[IdxW'(BlockWidth - 1 - k * BusWidth) -: BusWidth] = data_i;
        end
      end
    end

    // A commit in the same cycle as the completing word still yields a single block.
    assign w_blk_wr  = (w_push_ok && (w_last || commit_i)) ||
                       (!w_full && commit_i && (r_wc != '0));
    assign w_blk     = w_asm_next;
    assign w_release = w_pop_ok;
    assign data_o    = w_head;
    assign partial_o = (r_wc != '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wc  <= '0;
        r_asm <= '0;
      end else if (flush_i) begin
        r_wc  <= '0;
        r_asm <= '0;
      end else if (w_blk_wr) begin
        r_wc  <= '0;
        r_asm <= '0;
      end else if (w_push_ok) begin
        r_wc  <= r_wc + 1'b1;
        r_asm <= w_asm_next;
      end
    end
  end else begin : g_downsize
    logic [CntW-1:0]     r_rc;
    logic [BusWidth-1:0] w_word;
    logic                w_last;
    logic                w_unused_commit;

    assign w_unused_commit = commit_i;
    assign w_last          = (r_rc == LastCnt);

    always_comb begin
      w_word = '0;
      for (int unsigned k = 0; k < R; k++) begin
        if (r_rc == CntW'(k))
          w_word = w_head[IdxW'(BlockWidth - 1 - k * BusWidth) -: BusWidth];
      end
    end

    assign w_blk_wr  = w_push_ok;
    assign w_blk     = data_i;
    assign w_release = w_pop_ok && w_last;
    assign data_o    = w_word;
    assign partial_o = (r_rc != '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rc <= '0;
      end else if (flush_i) begin
        r_rc <= '0;
      end else if (w_pop_ok) begin
        r_rc <= w_last ? '0 : r_rc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ascon_width_fifo.sv
// Directed bench for ascon_width_fifo: one upsize and one downsize instance, 32/64 bit, depth 4.
module tb_ascon_width_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        u_flush = 1'b0, u_push = 1'b0, u_pop = 1'b0, u_commit = 1'b0;
  logic [31:0] u_din = '0;
  logic        u_full, u_empty, u_partial;
  logic [2:0]  u_level;
  logic [63:0] u_dout;

  logic        d_flush = 1'b0, d_push = 1'b0, d_pop = 1'b0, d_commit = 1'b0;
  logic [63:0] d_din = '0;
  logic        d_full, d_empty, d_partial;
  logic [2:0]  d_level;
  logic [31:0] d_dout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ascon_width_fifo #(.BusWidth(32), .BlockWidth(64), .Depth(4), .Mode(0)) u_up (
    .clk(clk), .rst(rst), .flush_i(u_flush), .push_i(u_push), .data_i(u_din),
    .commit_i(u_commit), .full_o(u_full), .pop_i(u_pop), .data_o(u_dout),
    .empty_o(u_empty), .level_o(u_level), .partial_o(u_partial)
  );

  ascon_width_fifo #(.BusWidth(32), .BlockWidth(64), .Depth(4), .Mode(1)) u_dn (
    .clk(clk), .rst(rst), .flush_i(d_flush), .push_i(d_push), .data_i(d_din),
    .commit_i(d_commit), .full_o(d_full), .pop_i(d_pop), .data_o(d_dout),
    .empty_o(d_empty), .level_o(d_level), .partial_o(d_partial)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic up_idle();
    u_flush = 1'b0; u_push = 1'b0; u_pop = 1'b0; u_commit = 1'b0;
  endtask

  task automatic dn_idle();
    d_flush = 1'b0; d_push = 1'b0; d_pop = 1'b0; d_commit = 1'b0;
  endtask

  task automatic up_push(input logic [31:0] w);
    u_push = 1'b1; u_din = w; step(); up_idle();
  endtask

  task automatic up_pop();
    u_pop = 1'b1; step(); up_idle();
  endtask

  task automatic dn_push(input logic [63:0] b);
    d_push = 1'b1; d_din = b; step(); dn_idle();
  endtask

  task automatic dn_pop();
    d_pop = 1'b1; step(); dn_idle();
  endtask

  task automatic check_reset_state(input string who);
    check({who, "_up_empty"},   64'(u_empty),   64'd1);
    check({who, "_up_full"},    64'(u_full),    64'd0);
    check({who, "_up_level"},   64'(u_level),   64'd0);
    check({who, "_up_partial"}, 64'(u_partial), 64'd0);
    check({who, "_up_data"},    u_dout,         64'd0);
    check({who, "_dn_empty"},   64'(d_empty),   64'd1);
    check({who, "_dn_full"},    64'(d_full),    64'd0);
    check({who, "_dn_level"},   64'(d_level),   64'd0);
    check({who, "_dn_partial"}, 64'(d_partial), 64'd0);
    check({who, "_dn_data"},    64'(d_dout),    64'd0);
  endtask

  initial begin
    // Reset
    #1 rst = 1'b1;
    #1 check_reset_state("rst");
    #10 rst = 1'b0;
    step();

    // Upsize: two words form one MSB-first block
    up_push(32'hAAAA_0001);
    check("up_half_partial", 64'(u_partial), 64'd1);
    check("up_half_empty",   64'(u_empty),   64'd1);
    up_push(32'hBBBB_0002);
    check("up_blk_level",   64'(u_level),   64'd1);
    check("up_blk_data",    u_dout,         64'hAAAA_0001_BBBB_0002);
    check("up_blk_partial", 64'(u_partial), 64'd0);
    up_pop();
    check("up_blk_popped", 64'(u_empty), 64'd1);

    // Upsize: commit of a partial block zero-pads
    up_push(32'h1234_5678);
    u_commit = 1'b1; step(); up_idle();
    check("up_commit_data",    u_dout,         64'h1234_5678_0000_0000);
    check("up_commit_level",   64'(u_level),   64'd1);
    check("up_commit_partial", 64'(u_partial), 64'd0);
    up_pop();

    // Commit together with the completing word: exactly one block
    up_push(32'hAAAA_0001);
    u_push = 1'b1; u_din = 32'h2222_2222; u_commit = 1'b1; step(); up_idle();
    check("up_pc_level", 64'(u_level), 64'd1);
    check("up_pc_data",  u_dout,       64'hAAAA_0001_2222_2222);
    up_pop();

    // Commit with nothing assembled is ignored
    u_commit = 1'b1; step(); up_idle();
    check("up_commit_empty", 64'(u_level), 64'd0);

    // Fill: 10 words, last two ignored
    for (int k = 0; k < 10; k++) up_push(32'h1000_0000 + 32'(k));
    check("up_fill_full",    64'(u_full),    64'd1);
    check("up_fill_level",   64'(u_level),   64'd4);
    check("up_fill_partial", 64'(u_partial), 64'd0);
    check("up_fill_head",    u_dout,         64'h1000_0000_1000_0001);
    // Push with pop while full: push ignored, pop taken
    u_push = 1'b1; u_din = 32'hDEAD_BEEF; u_pop = 1'b1; step(); up_idle();
    check("up_fullpp_level",   64'(u_level),   64'd3);
    check("up_fullpp_partial", 64'(u_partial), 64'd0);
    for (int k = 1; k < 4; k++) begin
      check("up_drain_data", u_dout, {32'h1000_0000 + 32'(2 * k), 32'h1000_0000 + 32'(2 * k + 1)});
      up_pop();
    end
    check("up_drain_empty", 64'(u_empty), 64'd1);
    up_pop();
    check("up_pop_on_empty", 64'(u_level), 64'd0);

    // Completing push with pop while empty: block stored, pop ignored
    up_push(32'h5555_0000);
    u_push = 1'b1; u_din = 32'h6666_0000; u_pop = 1'b1; step(); up_idle();
    check("up_emptypp_level", 64'(u_level), 64'd1);
    check("up_emptypp_data",  u_dout,       64'h5555_0000_6666_0000);
    up_pop();

    // Stream 20 blocks: one block in, one block out per step
    up_push(32'hC000_0000);
    up_push(32'hD000_0000);
    for (int k = 1; k < 20; k++) begin
      up_push(32'hC000_0000 + 32'(k));
      check("up_stream_data", u_dout, {32'hC000_0000 + 32'(k - 1), 32'hD000_0000 + 32'(k - 1)});
      u_push = 1'b1; u_din = 32'hD000_0000 + 32'(k); u_pop = 1'b1; step(); up_idle();
      check("up_stream_level", 64'(u_level), 64'd1);
    end
    check("up_stream_last", u_dout, 64'hC000_0013_D000_0013);
    up_pop();

    // Flush beats push/pop
    for (int k = 0; k < 7; k++) up_push(32'h7000_0000 + 32'(k));
    check("up_preflush_level",   64'(u_level),   64'd3);
    check("up_preflush_partial", 64'(u_partial), 64'd1);
    u_flush = 1'b1; u_push = 1'b1; u_din = 32'h7777_7777; u_pop = 1'b1; step(); up_idle();
    check("up_flush_level",   64'(u_level),   64'd0);
    check("up_flush_empty",   64'(u_empty),   64'd1);
    check("up_flush_partial", 64'(u_partial), 64'd0);
    up_push(32'h1111_1111);
    u_commit = 1'b1; step(); up_idle();
    check("up_postflush_data",  u_dout,       64'h1111_1111_0000_0000);
    check("up_postflush_level", 64'(u_level), 64'd1);
    up_pop();

    // Downsize: one block read as two words
    dn_push(64'h0102_0304_0506_0708);
    check("dn_level",     64'(d_level),   64'd1);
    check("dn_word0",     64'(d_dout),    64'h0102_0304);
    check("dn_partial0",  64'(d_partial), 64'd0);
    dn_pop();
    check("dn_word1",     64'(d_dout),    64'h0506_0708);
    check("dn_partial1",  64'(d_partial), 64'd1);
    check("dn_level_mid", 64'(d_level),   64'd1);
    dn_pop();
    check("dn_level_end", 64'(d_level),   64'd0);
    check("dn_empty_end", 64'(d_empty),   64'd1);
    check("dn_partial_end", 64'(d_partial), 64'd0);

    // Downsize fill: fifth block ignored, push/commit during full ignored
    for (int k = 0; k < 5; k++) dn_push({32'hE000_0000 + 32'(k), 32'hF000_0000 + 32'(k)});
    check("dn_fill_full",  64'(d_full),  64'd1);
    check("dn_fill_level", 64'(d_level), 64'd4);
    check("dn_fill_w0",    64'(d_dout),  64'hE000_0000);
    d_push = 1'b1; d_din = 64'h9999_9999_9999_9999; d_pop = 1'b1; d_commit = 1'b1; step(); dn_idle();
    check("dn_fullpp_level", 64'(d_level), 64'd4);
    check("dn_fullpp_word",  64'(d_dout),  64'hF000_0000);
    dn_pop();
    for (int k = 1; k < 4; k++) begin
      check("dn_drain_hi", 64'(d_dout), 64'(32'hE000_0000 + 32'(k)));
      dn_pop();
      check("dn_drain_lo", 64'(d_dout), 64'(32'hF000_0000 + 32'(k)));
      dn_pop();
    end
    check("dn_drain_empty", 64'(d_empty), 64'd1);
    dn_pop();
    check("dn_pop_on_empty", 64'(d_level), 64'd0);

    // Downsize push and pop together while not full/empty
    dn_push(64'hAAAA_AAAA_BBBB_BBBB);
    d_push = 1'b1; d_din = 64'hCCCC_CCCC_DDDD_DDDD; d_pop = 1'b1; step(); dn_idle();
    check("dn_pp_level", 64'(d_level), 64'd2);
    check("dn_pp_word",  64'(d_dout),  64'hBBBB_BBBB);
    dn_pop();
    check("dn_pp_next_level", 64'(d_level), 64'd1);
    check("dn_pp_next_word",  64'(d_dout),  64'hCCCC_CCCC);

    // Async reset mid-stream on both instances
    up_push(32'h4444_0000);
    up_push(32'h4444_0001);
    up_push(32'h4444_0002);
    dn_pop();
    check("pre_rst_up_partial", 64'(u_partial), 64'd1);
    check("pre_rst_dn_partial", 64'(d_partial), 64'd1);
    #1 rst = 1'b1;
    #1 check_reset_state("async_rst");
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
